led_frame_scheduler: RTL

- Frame-level controller sitting between pixel producers (switch logic, effect engines) and led_driver.
- Holds a double-buffered per-LED colour store and starts a strand refresh at a fixed frame rate.
- Serves led_driver's per-LED colour requests from the front bank, then issues the strand latch (force_reset) and swaps banks on request at frame end.

---
 rtl/led_frame_scheduler_pkg.sv | 25 ++
 rtl/led_frame_scheduler_ram.sv | 50 +++++
 rtl/led_frame_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and default timing for the LED frame scheduler.
package led_pkg;

   localparam int LP_COLOR_WIDTH  = 8;
   localparam int LP_FRAME_CYCLES = 1_666_667;  // 60 Hz frame at 100 MHz
   localparam int LP_LATCH_CYCLES = 28_000;     // 280 us strand latch at 100 MHz

   typedef struct packed {
      logic [LP_COLOR_WIDTH-1:0] green;
      logic [LP_COLOR_WIDTH-1:0] red;
      logic [LP_COLOR_WIDTH-1:0] blue;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      LATCH  = 2'd2
   } sched_state_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_frame_scheduler_ram.sv
// Double-buffered colour store: host writes the back bank, driver reads the front bank.
module rgb_pingpong_ram #(
   parameter int NUM_LEDS   = 2,
   parameter int DATA_WIDTH = 24,
   parameter int IDX_WIDTH  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_front,
   input  logic                  i_wr_en,
   input  logic [IDX_WIDTH-1:0]  i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [IDX_WIDTH-1:0]  i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   // One extra bit so NUM_LEDS itself is representable for the range compare.
   localparam int                 LP_AW  = IDX_WIDTH + 1;
   localparam logic [LP_AW-1:0]   LP_NUM = LP_AW'(NUM_LEDS);

   logic [DATA_WIDTH-1:0] r_mem [0:1][0:NUM_LEDS-1];
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  w_back;
   logic                  w_wr_ok;
   logic                  w_rd_ok;

   assign w_back  = ~i_front;
   assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < LP_NUM);
   assign w_rd_ok = {1'b0, i_rd_addr} < LP_NUM;

   // Back-bank write; the array itself is never reset.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[w_back][i_wr_addr] <= i_wr_data;
      end
   end

   // Registered front-bank read; out-of-range indices answer with black.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= w_rd_ok ? r_mem[i_front][i_rd_addr] : '0;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame-rate controller: serves led_driver colour requests, latches the strand, swaps banks.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a frame tick with enable_in high
//   STREAM | answering driver requests from the front bank
//   LATCH  | strand latch hold; force_reset and bank swap on first cycle
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter  int NUM_LEDS     = 2,
   parameter  int COLOR_WIDTH  = LP_COLOR_WIDTH,
   parameter  int FRAME_CYCLES = LP_FRAME_CYCLES,
   parameter  int LATCH_CYCLES = LP_LATCH_CYCLES,
   localparam int IDX_WIDTH    = cnt_width(NUM_LEDS)
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   enable_in,
   input  logic                   wr_en_in,
   input  logic [IDX_WIDTH-1:0]   wr_addr_in,
   input  logic [COLOR_WIDTH-1:0] wr_green_in,
   input  logic [COLOR_WIDTH-1:0] wr_red_in,
   input  logic [COLOR_WIDTH-1:0] wr_blue_in,
   input  logic                   swap_req_in,
   output logic                   swap_ack_out,
   input  logic [IDX_WIDTH-1:0]   drv_req_idx_in,
   input  logic                   drv_req_valid_in,
   output logic [COLOR_WIDTH-1:0] green_out,
   output logic [COLOR_WIDTH-1:0] red_out,
   output logic [COLOR_WIDTH-1:0] blue_out,
   output logic                   color_valid_out,
   output logic                   force_reset_out,
   output logic [15:0]            frame_count_out,
   output logic                   overrun_out
);

   localparam int                     TMR_WIDTH   = cnt_width(FRAME_CYCLES);
   localparam int                     LAT_WIDTH   = cnt_width(LATCH_CYCLES);
   localparam logic [TMR_WIDTH-1:0]   LP_TMR_LAST = TMR_WIDTH'(FRAME_CYCLES - 1);
   localparam logic [LAT_WIDTH-1:0]   LP_LAT_LAST = LAT_WIDTH'(LATCH_CYCLES - 1);
   localparam logic [IDX_WIDTH-1:0]   LP_IDX_LAST = IDX_WIDTH'(NUM_LEDS - 1);

   sched_state_t             r_state;
   sched_state_t             w_state_nxt;
   logic [TMR_WIDTH-1:0]     r_timer;
   logic [LAT_WIDTH-1:0]     r_latch_cnt;
   logic                     r_front;
   logic                     r_swap_pending;
   logic                     r_last_req;
   logic                     r_valid;
   logic [15:0]              r_frame_cnt;
   logic                     r_overrun;
   logic                     w_tick;
   logic                     w_req_accept;
   logic                     w_swap;
   logic                     w_force;
   logic                     w_latch_done;
   logic [3*COLOR_WIDTH-1:0] w_rd_data;

   assign w_tick       = (r_timer == LP_TMR_LAST);
   // Once the last LED has been requested, further requests are dropped so the
   // colour outputs hold through LATCH.
   assign w_req_accept = (r_state == STREAM) && drv_req_valid_in && !r_last_req;
   assign w_latch_done = (r_state == LATCH) && (r_latch_cnt == '0);

   // Free-running frame timer; the wrap cycle is the frame tick.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_timer <= '0;
      end else if (w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and first-LATCH-cycle strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      w_force     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick && enable_in) begin
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (r_last_req) begin
               w_state_nxt = LATCH;
            end
         end
         LATCH: begin
            if (r_latch_cnt == LP_LAT_LAST) begin
               w_force = 1'b1;
               w_swap  = r_swap_pending || swap_req_in;
            end
            if (r_latch_cnt == '0) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Latch hold down-counter, loaded on the way into LATCH.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_latch_cnt <= '0;
      end else if ((r_state == STREAM) && r_last_req) begin
         r_latch_cnt <= LP_LAT_LAST;
      end else if ((r_state == LATCH) && (r_latch_cnt != '0)) begin
         r_latch_cnt <= r_latch_cnt - 1'b1;
      end
   end

   // Stream bookkeeping: last-LED flag and colour-valid qualifier.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_last_req <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         if (w_req_accept && (drv_req_idx_in == LP_IDX_LAST)) begin
            r_last_req <= 1'b1;
         end else if ((r_state == STREAM) && r_last_req) begin
            r_last_req <= 1'b0;
         end
         if (w_state_nxt != STREAM) begin
            r_valid <= 1'b0;
         end else if (w_req_accept) begin
            r_valid <= 1'b1;
         end
      end
   end

   // Bank select and a single pending swap request.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_front        <= 1'b0;
         r_swap_pending <= 1'b0;
      end else if (w_swap) begin
         r_front        <= ~r_front;
         r_swap_pending <= 1'b0;
      end else if (swap_req_in) begin
         r_swap_pending <= 1'b1;
      end
   end

   // Completed-frame counter and sticky overrun flag.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_frame_cnt <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_latch_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_tick && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   rgb_pingpong_ram #(
      .NUM_LEDS   (NUM_LEDS),
      .DATA_WIDTH (3 * COLOR_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_ram (
      .i_clk      (clk_in),
      .i_rst_n    (rst_n_in),
      .i_front    (r_front),
      .i_wr_en    (wr_en_in),
      .i_wr_addr  (wr_addr_in),
      .i_wr_data  ({wr_green_in, wr_red_in, wr_blue_in}),
      .i_rd_en    (w_req_accept),
      .i_rd_addr  (drv_req_idx_in),
      .o_rd_data  (w_rd_data)
   );

   assign green_out       = w_rd_data[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
   assign red_out         = w_rd_data[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
   assign blue_out        = w_rd_data[COLOR_WIDTH-1:0];
   assign color_valid_out = r_valid;
   assign force_reset_out = w_force;
   assign swap_ack_out    = w_swap;
   assign frame_count_out = r_frame_cnt;
   assign overrun_out     = r_overrun;

endmodule
